serial_adder_seq: RTL and testbench
===================================

// Module: serial_adder_seq
// PURPOSE
//  Sequencer for a 1-bit XOR/carry add cell: computes a WIDTH-bit sum bit-serially, LSB first,
//  one bit per clock through a single shared full-adder slice. Sits between a requester
//  (start/done handshake) and the 1-bit datapath; owns operand shifting, carry state and result capture.
// PARAMETERS
//  WIDTH   8   operand/result width in bits; legal range 2..32
//  CNT_W   $clog2(WIDTH)+1   localparam, bit counter width (not overridable)
// PORTS
//  clk        in   1      clock, all state on rising edge
//  rst        in   1      asynchronous active-high reset
//  start      in   1      request; accepted only when ready=1
//  a          in   WIDTH  operand A, sampled on accepted start
//  b          in   WIDTH  operand B, sampled on accepted start
//  sub        in   1      subtract select (present only with SERIAL_ADDER_SUB_EN)
//  ready      out  1      block idle, start will be accepted
//  busy       out  1      serial operation in progress
//  done       out  1      one-cycle pulse, sum/carry_out just updated
//  sum        out  WIDTH  result register, held until next completion
//  carry_out  out  1      final carry, held with sum
// BEHAVIOUR
//  - Clock clk, reset rst: asynchronous, active-high. Reset values: ready=1, busy=0, done=0,
//    sum=0, carry_out=0, FSM=IDLE, counter=0, carry reg=0, shift regs=0.
//  - FSM states: IDLE -> RUN (start&ready) ; RUN -> DONE (counter==WIDTH-1 at edge) ; DONE -> IDLE.
//  - IDLE: ready=1. On start: latch a->sa, b->sb, carry reg=0, counter=0, enter RUN.
//  - RUN (exactly WIDTH cycles): s = sa[0]^sb[0]^c; c <= maj(sa[0],sb[0],c);
//    sa,sb shift right by 1; s shifted into MSB of result shift reg; counter++. busy=1, ready=0.
//  - On last RUN cycle: sum <= completed result, carry_out <= final carry; enter DONE.
//  - DONE: done=1 for one cycle, busy=0, ready=0; then IDLE.
//  - Latency: start accepted at edge N -> done high in cycle N+WIDTH+1; next start accepted
//    at edge N+WIDTH+2 earliest. Throughput one op per WIDTH+2 cycles.
//  - start while ready=0 (RUN or DONE) ignored, no queuing; a/b changes during RUN have no effect.
//  - sum/carry_out change only on completion; stable throughout a subsequent RUN.
//  - Arithmetic modulo 2^WIDTH; overflow reported only via carry_out.
//  - rst asserted mid-RUN: operation aborted, all outputs to reset values, no done pulse.
// CONFIGURATION
//  SERIAL_ADDER_SUB_EN defined: port sub exists; on accepted start with sub=1, sb latched as ~b
//    and carry reg initialised to 1 -> sum = a-b mod 2^WIDTH, carry_out=1 means no borrow (a>=b).
//    sub=0 behaves as plain add.
//  SERIAL_ADDER_SUB_EN undefined: no sub port; always add with carry-in 0.
// TESTING (WIDTH=8)
//  - rst pulse, no start -> ready=1, busy=0, done=0, sum=0x00, carry_out=0 indefinitely.
//  - start a=0x5A b=0xA5 -> busy 8 cycles, done pulse 9 cycles after start edge, sum=0xFF, carry_out=0.
//  - start a=0xFF b=0x01 -> sum=0x00, carry_out=1; done exactly one cycle wide.
//  - start a=0x03 b=0x04, then start a=0xFF b=0xFF at cycle 3 -> second ignored, sum=0x07, carry_out=0;
//    sum from previous op unchanged until this done.
//  - start a=0x80 b=0x80, assert rst at cycle 4 -> ready=1, sum=0x00, carry_out=0, no done pulse.
//  - SUB_EN: a=0x10 b=0x01 sub=1 -> sum=0x0F carry_out=1; a=0x01 b=0x02 sub=1 -> sum=0xFF carry_out=0.

Source files
------------

// File: rtl/serial_adder_seq.sv
// Bit-serial WIDTH-bit adder sequencer: one full-adder slice, LSB first, one bit per clock.
// Optional subtract mode (sub port) is enabled by defining SERIAL_ADDER_SUB_EN.
module serial_adder_seq #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out,
    output logic [1:0]       dbg_state
);

    // Handshake: a request is taken on a rising edge where start=1 and ready=1; done is a
    // one-cycle strobe marking sum/carry_out as freshly updated. No request is ever queued.

    localparam int CNT_W = $clog2(WIDTH) + 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       state;
    logic [CNT_W-1:0] cnt;
    logic             c;
    logic [WIDTH-1:0] sa;
    logic [WIDTH-1:0] sb;
    logic [WIDTH-1:0] acc;
    logic             sub_sel;
    logic             s_bit;
    logic             c_nxt;
    logic [WIDTH-1:0] acc_nxt;

`ifdef SERIAL_ADDER_SUB_EN
    assign sub_sel = sub;
`else
    assign sub_sel = 1'b0;
`endif

    // The shared full-adder slice
    assign s_bit   = sa[0] ^ sb[0] ^ c;
    assign c_nxt   = (sa[0] & sb[0]) | (sa[0] & c) | (sb[0] & c);
    assign acc_nxt = {s_bit, acc[WIDTH-1:1]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            cnt       <= '0;
            c         <= 1'b0;
            sa        <= '0;
            sb        <= '0;
            acc       <= '0;
            sum       <= '0;
            carry_out <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        sa    <= a;
                        // Subtraction is a + ~b + 1: invert b and seed the carry.
                        sb    <= sub_sel ? ~b : b;
                        c     <= sub_sel;
                        cnt   <= '0;
                        state <= S_RUN;
                    end
                end
                S_RUN: begin
                    sa  <= sa >> 1;
                    sb  <= sb >> 1;
                    c   <= c_nxt;
                    acc <= acc_nxt;
                    cnt <= cnt + CNT_W'(1);
                    if (cnt == CNT_W'(WIDTH - 1)) begin
                        sum       <= acc_nxt;
                        carry_out <= c_nxt;
                        state     <= S_DONE;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign ready     = (state == S_IDLE);
    assign busy      = (state == S_RUN);
    assign done      = (state == S_DONE);
    assign dbg_state = state;

endmodule

// File: tb/tb_serial_adder_seq.sv
// Self-checking bench for serial_adder_seq (WIDTH=8); subtract scenarios run only when
// SERIAL_ADDER_SUB_EN is defined.
module tb_serial_adder_seq;

  localparam int W = 8;

  logic         clk;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         sub;
  logic         ready;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         carry_out;
  logic [1:0]   dbg_state;

  int checks   = 0;
  int failures = 0;

  // Each entry is {carry_out, sum} expected for one accepted request.
  logic [W:0] exp_q[$];

  serial_adder_seq #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .a         (a),
    .b         (b),
`ifdef SERIAL_ADDER_SUB_EN
    .sub       (sub),
`endif
    .ready     (ready),
    .busy      (busy),
    .done      (done),
    .sum       (sum),
    .carry_out (carry_out),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- model ----------------
  function automatic logic [W:0] model(input logic [W-1:0] av, input logic [W-1:0] bv,
                                       input logic sv);
    logic [W-1:0] bb;
    bb = ~bv;
    if (sv) return {1'b0, av} + {1'b0, bb} + (W+1)'(1);
    else    return {1'b0, av} + {1'b0, bv};
  endfunction

  // ---------------- drivers ----------------
  // Presents a request at a falling edge, lets the next rising edge accept it, and
  // returns at the following falling edge with start released (sample point k=0).
  task automatic drive_start(input logic [W-1:0] av, input logic [W-1:0] bv, input logic sv);
    @(negedge clk);
    start = 1'b1;
    a     = av;
    b     = bv;
    sub   = sv;
    exp_q.push_back(model(av, bv, sv));
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
  endtask

  // Watches falling edges after the accepting edge; lat = edges until done seen (-1 = timeout).
  task automatic wait_done(output int lat, output int busy_cycles,
                           output logic [W-1:0] got_sum, output logic got_cout);
    lat         = -1;
    busy_cycles = 0;
    got_sum     = '0;
    got_cout    = 1'b0;
    for (int k = 0; k < W + 6; k++) begin
      if (k > 0) @(negedge clk);
      if (busy) busy_cycles++;
      if (done) begin
        lat      = k;
        got_sum  = sum;
        got_cout = carry_out;
        break;
      end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if ({ready, busy, done, carry_out, sum, dbg_state} !== {1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 2'd0}) begin
        failures++;
        $display("FAIL reset_idle cyc=%0d got ready=%b busy=%b done=%b cout=%b sum=%h st=%0d want 1 0 0 0 00 0",
                 i, ready, busy, done, carry_out, sum, dbg_state);
      end
    end
  endtask

  task automatic check_op(input string name, input int lat, input int bc,
                          input logic [W-1:0] gs, input logic gc);
    logic [W:0] exp;
    checks++;
    if (lat !== W) begin
      failures++;
      $display("FAIL %s_latency got=%0d want=%0d", name, lat, W);
    end
    checks++;
    if (bc !== W) begin
      failures++;
      $display("FAIL %s_busy_cycles got=%0d want=%0d", name, bc, W);
    end
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $display("FAIL %s_scoreboard got=empty_queue want=entry", name);
    end else begin
      exp = exp_q.pop_front();
      if ({gc, gs} !== exp) begin
        failures++;
        $display("FAIL %s_result got cout=%b sum=%h want cout=%b sum=%h", name, gc, gs, exp[W], exp[W-1:0]);
      end
    end
  endtask

  task automatic test_add_basic();
    int lat, bc;
    logic [W-1:0] gs;
    logic gc;
    drive_start(8'h5A, 8'hA5, 1'b0);
    wait_done(lat, bc, gs, gc);
    check_op("add_5a_a5", lat, bc, gs, gc);
  endtask

  task automatic test_overflow();
    int lat, bc;
    logic [W-1:0] gs;
    logic gc;
    drive_start(8'hFF, 8'h01, 1'b0);
    wait_done(lat, bc, gs, gc);
    check_op("add_ff_01", lat, bc, gs, gc);
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || ready !== 1'b1) begin
      failures++;
      $display("FAIL done_width got done=%b ready=%b want done=0 ready=1", done, ready);
    end
  endtask

  task automatic test_ignored_start();
    int lat, bc;
    logic [W-1:0] gs, prev_sum;
    logic gc, prev_cout;
    prev_sum  = sum;
    prev_cout = carry_out;
    drive_start(8'h03, 8'h04, 1'b0);
    lat = -1; bc = 0; gs = '0; gc = 1'b0;
    for (int k = 0; k < W + 6; k++) begin
      if (k > 0) @(negedge clk);
      if (k == 3) begin
        start = 1'b1; a = 8'hFF; b = 8'hFF;
      end else begin
        start = 1'b0;
      end
      if (busy) bc++;
      if (done) begin
        lat = k; gs = sum; gc = carry_out;
        break;
      end
      checks++;
      if (sum !== prev_sum || carry_out !== prev_cout) begin
        failures++;
        $display("FAIL held_result k=%0d got cout=%b sum=%h want cout=%b sum=%h",
                 k, carry_out, sum, prev_cout, prev_sum);
      end
    end
    start = 1'b0;
    check_op("ignored_start", lat, bc, gs, gc);
    // The ignored request must not have been latched for later.
    repeat (3) @(negedge clk);
    checks++;
    if (ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
      failures++;
      $display("FAIL no_queued_op got ready=%b busy=%b done=%b want 1 0 0", ready, busy, done);
    end
  endtask

  task automatic test_reset_mid_run();
    int done_seen;
    drive_start(8'h80, 8'h80, 1'b0);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    exp_q.delete();
    #1;
    checks++;
    if ({ready, busy, done, carry_out, sum, dbg_state} !== {1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 2'd0}) begin
      failures++;
      $display("FAIL reset_abort got ready=%b busy=%b done=%b cout=%b sum=%h st=%0d want 1 0 0 0 00 0",
               ready, busy, done, carry_out, sum, dbg_state);
    end
    @(negedge clk);
    rst = 1'b0;
    done_seen = 0;
    for (int k = 0; k < W + 4; k++) begin
      @(negedge clk);
      if (done) done_seen++;
    end
    checks++;
    if (done_seen !== 0 || sum !== 8'h00 || ready !== 1'b1) begin
      failures++;
      $display("FAIL no_done_after_abort got dones=%0d sum=%h ready=%b want 0 00 1", done_seen, sum, ready);
    end
  endtask

  task automatic test_back_to_back();
    int lat, bc;
    logic [W-1:0] gs, av, bv;
    logic gc;
    logic [W-1:0] tab_a[4] = '{8'h00, 8'hFF, 8'h7F, 8'hAA};
    logic [W-1:0] tab_b[4] = '{8'h00, 8'hFF, 8'h01, 8'h55};
    drive_start(8'h12, 8'h34, 1'b0);
    for (int i = 0; i < 8; i++) begin
      wait_done(lat, bc, gs, gc);
      check_op("b2b", lat, bc, gs, gc);
      if (i < 4) begin
        av = tab_a[i]; bv = tab_b[i];
      end else begin
        av = W'($urandom_range(0, 255)); bv = W'($urandom_range(0, 255));
      end
      // Request raised during DONE: not taken there, taken at the next (IDLE) edge.
      start = 1'b1; a = av; b = bv; sub = 1'b0;
      exp_q.push_back(model(av, bv, 1'b0));
      @(negedge clk);
      checks++;
      if (ready !== 1'b1 || busy !== 1'b0) begin
        failures++;
        $display("FAIL start_in_done got ready=%b busy=%b want ready=1 busy=0", ready, busy);
      end
      @(negedge clk);
      start = 1'b0;
    end
    wait_done(lat, bc, gs, gc);
    check_op("b2b_last", lat, bc, gs, gc);
  endtask

`ifdef SERIAL_ADDER_SUB_EN
  task automatic test_sub();
    int lat, bc;
    logic [W-1:0] gs;
    logic gc;
    drive_start(8'h10, 8'h01, 1'b1);
    wait_done(lat, bc, gs, gc);
    check_op("sub_10_01", lat, bc, gs, gc);
    drive_start(8'h01, 8'h02, 1'b1);
    wait_done(lat, bc, gs, gc);
    check_op("sub_01_02", lat, bc, gs, gc);
    drive_start(8'h33, 8'h33, 1'b1);
    wait_done(lat, bc, gs, gc);
    check_op("sub_equal", lat, bc, gs, gc);
  endtask
`endif

  // ---------------- sequence / report ----------------
  initial begin
    rst   = 1'b1;
    start = 1'b0;
    a     = '0;
    b     = '0;
    sub   = 1'b0;
    test_reset();
    test_add_basic();
    test_overflow();
    test_ignored_start();
    test_reset_mid_run();
    test_back_to_back();
`ifdef SERIAL_ADDER_SUB_EN
    test_sub();
`endif
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain got=%0d want=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
